// File: rtl/hx711_pkg.sv
// Shared encodings for the HX711 reader: gain/channel modes, FSM states and
// the per-mode SCK pulse count.
package hx711_pkg;

  localparam logic [1:0] MODE_A128 = 2'b00;
  localparam logic [1:0] MODE_B32  = 2'b01;
  localparam logic [1:0] MODE_A64  = 2'b10;

  typedef logic [2:0] state_t;
  localparam state_t ST_ARM   = 3'd0;
  localparam state_t ST_IDLE  = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_CFG   = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Mode 11 is undefined on the HX711 and falls back to channel A, gain 128.
  function automatic logic [4:0] pulse_count(input logic [1:0] m);
    case (m)
      MODE_B32: return 5'd26;
      MODE_A64: return 5'd27;
      default:  return 5'd25;
    endcase
  endfunction

endpackage

// File: rtl/hx711_sck_gen.sv
// PD_SCK generator: HALF_CYC-cycle high and low phases, a pulse counter, and
// strobes marking the data sample point and the end of each pulse.
module hx711_sck_gen #(
  parameter int unsigned HALF_CYC = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [4:0] n_pulses_i,
  output logic       pd_sck_o,
  output logic       sample_o,
  output logic       pulse_end_o,
  output logic       last_o,
  output logic [4:0] pulse_idx_o
);

  localparam int unsigned CW = (HALF_CYC > 2) ? $clog2(HALF_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HALF_CYC - 1);

  logic          active_q, active_d;
  logic          sck_q, sck_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    pulse_q, pulse_d;
  logic          phase_end_s;

  assign phase_end_s = active_q && (cnt_q == CNT_MAX);
  assign sample_o    = phase_end_s && sck_q;
  assign pulse_end_o = phase_end_s && !sck_q;
  assign last_o      = pulse_end_o && (pulse_q == (n_pulses_i - 5'd1));
  assign pd_sck_o    = sck_q;
  assign pulse_idx_o = pulse_q;

  // Phase/pulse sequencing; pd_sck is registered so it never glitches.
  always_comb begin
    active_d = active_q;
    sck_d    = sck_q;
    cnt_d    = cnt_q;
    pulse_d  = pulse_q;
    if (start_i) begin
      active_d = 1'b1;
      sck_d    = 1'b1;
      cnt_d    = {CW{1'b0}};
      pulse_d  = 5'd0;
    end else if (active_q) begin
      if (phase_end_s) begin
        cnt_d = {CW{1'b0}};
        if (sck_q) begin
          sck_d = 1'b0;
        end else begin
          pulse_d = pulse_q + 5'd1;
          if (last_o) begin
            active_d = 1'b0;
          end else begin
            sck_d = 1'b1;
          end
        end
      end else begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      sck_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      pulse_q  <= 5'd0;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

endmodule

// File: rtl/hx711_reader_p.sv
// HX711 reader: conversion FSM, 24-bit shift register, N-sample averager,
// tare offset, gramme scaling and DOUT-ready timeout.
module hx711_reader_p
  import hx711_pkg::*;
#(
  parameter int unsigned HALF_CYC    = 32,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned SCALE       = 152,
  parameter int unsigned TIMEOUT_CYC = 50000000
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        dout,
  output logic        pd_sck,
  input  logic [1:0]  mode,
  input  logic        tare_req,
  output logic [23:0] raw,
  output logic        raw_valid,
  output logic [31:0] value_gramme,
  output logic        value_valid,
  output logic        busy,
  output logic        timeout
);

  localparam logic [4:0]  AVG_N  = 5'(1 << AVG_LOG2);
  localparam logic [31:0] TO_MAX = 32'(TIMEOUT_CYC);
  localparam logic [31:0] SCL    = 32'(SCALE);

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [23:0] shift_q, shift_d, raw_q, raw_d, offset_q, offset_d;
  logic [27:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] value_q, value_d, tcnt_q, tcnt_d;
  logic        raw_valid_q, raw_valid_d, value_valid_q, value_valid_d;
  logic        avg_pend_q, avg_pend_d, tare_pend_q, tare_pend_d;
  logic        busy_q, busy_d, timeout_q, timeout_d;

  logic        start_s, sample_s, pulse_end_s, last_s;
  logic [4:0]  pulse_idx_s;
  logic [23:0] avg_s;
  logic [24:0] diff_s;
  logic [31:0] prod_s;

  assign start_s = (state_q == ST_IDLE) && !dout;

  hx711_sck_gen #(.HALF_CYC(HALF_CYC)) u_sck (
    .clk_i       (clk_50),
    .rst_i       (rst),
    .start_i     (start_s),
    .n_pulses_i  (pulse_count(mode_q)),
    .pd_sck_o    (pd_sck),
    .sample_o    (sample_s),
    .pulse_end_o (pulse_end_s),
    .last_o      (last_s),
    .pulse_idx_o (pulse_idx_s)
  );

  // Arithmetic shift right by AVG_LOG2, keeping the 24 significant bits.
  assign avg_s  = acc_q[AVG_LOG2 +: 24];
  assign diff_s = {avg_s[23], avg_s} - {offset_q[23], offset_q};
  assign prod_s = {{7{diff_s[24]}}, diff_s} * SCL;

  // Conversion FSM, averaging, tare and timeout next-state logic.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    shift_d       = shift_q;
    raw_d         = raw_q;
    offset_d      = offset_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    value_d       = value_q;
    tcnt_d        = tcnt_q;
    timeout_d     = timeout_q;
    raw_valid_d   = 1'b0;
    value_valid_d = 1'b0;
    avg_pend_d    = 1'b0;
    tare_pend_d   = tare_pend_q | tare_req;

    case (state_q)
      ST_ARM: begin
        if (dout) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_IDLE: begin
        if (!dout) begin
          state_d   = ST_SHIFT;
          mode_d    = mode;
          timeout_d = 1'b0;
          tcnt_d    = 32'd0;
        end else begin
          if (tcnt_q < TO_MAX) begin
            tcnt_d = tcnt_q + 32'd1;
          end else begin
            tcnt_d = tcnt_q;
          end
          if (tcnt_q >= (TO_MAX - 32'd1)) begin
            timeout_d = 1'b1;
          end else begin
            timeout_d = timeout_q;
          end
        end
      end
      ST_SHIFT: begin
        if (sample_s) begin
          shift_d = {shift_q[22:0], dout};
        end else begin
          shift_d = shift_q;
        end
        if (pulse_end_s && (pulse_idx_s == 5'd23)) begin
          state_d = ST_CFG;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_CFG: begin
        if (last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CFG;
        end
      end
      ST_DONE: begin
        raw_d       = shift_q;
        raw_valid_d = 1'b1;
        acc_d       = acc_q + {{4{shift_q[23]}}, shift_q};
        cnt_d       = cnt_q + 5'd1;
        avg_pend_d  = (cnt_q == (AVG_N - 5'd1));
        state_d     = ST_ARM;
      end
      default: begin
        state_d = ST_ARM;
      end
    endcase

    // Result cycle always lands in ARM, so it never collides with DONE.
    if (avg_pend_q) begin
      value_valid_d = 1'b1;
      acc_d         = 28'd0;
      cnt_d         = 5'd0;
      if (tare_pend_q) begin
        offset_d    = avg_s;
        value_d     = 32'd0;
        tare_pend_d = tare_req;
      end else begin
        value_d = prod_s;
      end
    end else begin
      value_d = value_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q       <= ST_ARM;
      mode_q        <= 2'b00;
      shift_q       <= 24'd0;
      raw_q         <= 24'd0;
      offset_q      <= 24'd0;
      acc_q         <= 28'd0;
      cnt_q         <= 5'd0;
      value_q       <= 32'd0;
      tcnt_q        <= 32'd0;
      timeout_q     <= 1'b0;
      raw_valid_q   <= 1'b0;
      value_valid_q <= 1'b0;
      avg_pend_q    <= 1'b0;
      tare_pend_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      shift_q       <= shift_d;
      raw_q         <= raw_d;
      offset_q      <= offset_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      value_q       <= value_d;
      tcnt_q        <= tcnt_d;
      timeout_q     <= timeout_d;
      raw_valid_q   <= raw_valid_d;
      value_valid_q <= value_valid_d;
      avg_pend_q    <= avg_pend_d;
      tare_pend_q   <= tare_pend_d;
      busy_q        <= busy_d;
    end
  end

  assign raw          = raw_q;
  assign raw_valid    = raw_valid_q;
  assign value_gramme = value_q;
  assign value_valid  = value_valid_q;
  assign busy         = busy_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_hx711_reader_p.sv
// Directed bench for hx711_reader_p: an HX711 pin model drives two readers
// (single-sample and 4-sample averaging) through hand-computed scenarios.
module tb_hx711_reader_p;

  localparam int HC = 4;
  localparam int TO = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, dout0, dout2, tare0, tare2;
  logic [1:0]  mode;
  logic        pd0, pd2, rv0, rv2, vv0, vv2, busy0, busy2, to0, to2;
  logic [23:0] raw0, raw2;
  logic [31:0] val0, val2;

  int n_chk = 0;
  int n_pass = 0;

  hx711_reader_p #(.HALF_CYC(HC), .AVG_LOG2(0), .SCALE(152), .TIMEOUT_CYC(TO)) u_dut0 (
    .clk_50(clk), .rst(rst), .dout(dout0), .pd_sck(pd0), .mode(mode), .tare_req(tare0),
    .raw(raw0), .raw_valid(rv0), .value_gramme(val0), .value_valid(vv0),
    .busy(busy0), .timeout(to0));

  hx711_reader_p #(.HALF_CYC(HC), .AVG_LOG2(2), .SCALE(152), .TIMEOUT_CYC(TO)) u_dut2 (
    .clk_50(clk), .rst(rst), .dout(dout2), .pd_sck(pd2), .mode(mode), .tare_req(tare2),
    .raw(raw2), .raw_valid(rv2), .value_gramme(val2), .value_valid(vv2),
    .busy(busy2), .timeout(to2));

  // Event capture: counts and last values of the valid pulses.
  int cyc = 0;
  int rv0_n = 0, vv0_n = 0, vv2_n = 0, rv0_t = 0, vv0_t = 0;
  logic [23:0] raw0_c = 24'd0;
  logic [31:0] val0_c = 32'd0, val2_c = 32'd0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rv0) begin rv0_n++; raw0_c = raw0; rv0_t = cyc; end
    if (vv0) begin vv0_n++; val0_c = val0; vv0_t = cyc; end
    if (vv2) begin vv2_n++; val2_c = val2; end
  end

  // HX711 model: pulls DOUT low, presents one bit per rising PD_SCK, goes high after bit 24.
  task automatic run_conv(input bit sel, input logic [23:0] code, input logic [1:0] m,
                          input logic [1:0] m_late, output int pulses, output int maxhigh);
    logic cur, prev;
    int hc, quiet;
    pulses = 0; maxhigh = 0; hc = 0; quiet = 0; prev = 1'b0;
    mode = m;
    @(negedge clk);
    if (sel) dout2 = 1'b0; else dout0 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      cur = sel ? pd2 : pd0;
      if (cur && !prev) begin
        if (pulses < 24) begin
          if (sel) dout2 = code[23-pulses]; else dout0 = code[23-pulses];
        end else begin
          if (sel) dout2 = 1'b1; else dout0 = 1'b1;
        end
        pulses++;
        if (pulses == 3) mode = m_late;
      end
      hc = cur ? hc + 1 : 0;
      if (hc > maxhigh) maxhigh = hc;
      quiet = (!cur && pulses > 0) ? quiet + 1 : 0;
      prev = cur;
      if (quiet > 4 * HC) break;
    end
    if (sel) dout2 = 1'b1; else dout0 = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dout0 = 1'b1; dout2 = 1'b1; tare0 = 1'b0; tare2 = 1'b0; mode = 2'b00;
    repeat (3) @(negedge clk);
    n_chk++; if (pd0 !== 1'b0) $display("FAIL reset_pd_sck got %b exp 0", pd0); else n_pass++;
    n_chk++; if (raw0 !== 24'd0) $display("FAIL reset_raw got %h exp 0", raw0); else n_pass++;
    n_chk++; if (val0 !== 32'd0) $display("FAIL reset_value got %h exp 0", val0); else n_pass++;
    n_chk++; if ({rv0, vv0, busy0, to0} !== 4'b0000)
      $display("FAIL reset_flags got %b exp 0000", {rv0, vv0, busy0, to0}); else n_pass++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++; if (busy0 !== 1'b0) $display("FAIL idle_busy got %b exp 0", busy0); else n_pass++;
  endtask

  task automatic test_mode00();
    int p, mh, rvn, vvn;
    rvn = rv0_n; vvn = vv0_n;
    run_conv(1'b0, 24'h000100, 2'b00, 2'b00, p, mh);
    n_chk++; if (p !== 25) $display("FAIL m00_pulses got %0d exp 25", p); else n_pass++;
    n_chk++; if (mh !== HC) $display("FAIL sck_high_len got %0d exp %0d", mh, HC); else n_pass++;
    n_chk++; if (rv0_n - rvn !== 1) $display("FAIL m00_raw_valid_cnt got %0d exp 1", rv0_n - rvn); else n_pass++;
    n_chk++; if (raw0_c !== 24'h000100) $display("FAIL m00_raw got %h exp 000100", raw0_c); else n_pass++;
    n_chk++; if (vv0_n - vvn !== 1) $display("FAIL m00_value_valid_cnt got %0d exp 1", vv0_n - vvn); else n_pass++;
    n_chk++; if (val0_c !== 32'd38912) $display("FAIL m00_value got %0d exp 38912", val0_c); else n_pass++;
    n_chk++; if (vv0_t - rv0_t !== 1) $display("FAIL m00_latency got %0d exp 1", vv0_t - rv0_t); else n_pass++;
  endtask

  task automatic test_modes();
    int p, mh;
    run_conv(1'b0, 24'h000100, 2'b01, 2'b01, p, mh);
    n_chk++; if (p !== 26) $display("FAIL m01_pulses got %0d exp 26", p); else n_pass++;
    run_conv(1'b0, 24'h000100, 2'b10, 2'b10, p, mh);
    n_chk++; if (p !== 27) $display("FAIL m10_pulses got %0d exp 27", p); else n_pass++;
    run_conv(1'b0, 24'h000100, 2'b11, 2'b11, p, mh);
    n_chk++; if (p !== 25) $display("FAIL m11_pulses got %0d exp 25", p); else n_pass++;
  endtask

  task automatic test_mode_change();
    int p, mh;
    run_conv(1'b0, 24'h000100, 2'b00, 2'b10, p, mh);
    n_chk++; if (p !== 25) $display("FAIL midchange_pulses got %0d exp 25", p); else n_pass++;
    run_conv(1'b0, 24'h000100, 2'b10, 2'b00, p, mh);
    n_chk++; if (p !== 27) $display("FAIL midchange2_pulses got %0d exp 27", p); else n_pass++;
  endtask

  task automatic test_negative();
    int p, mh;
    run_conv(1'b0, 24'hFFFF00, 2'b00, 2'b00, p, mh);
    n_chk++; if (raw0_c !== 24'hFFFF00) $display("FAIL neg_raw got %h exp FFFF00", raw0_c); else n_pass++;
    n_chk++; if (val0_c !== 32'hFFFF6800) $display("FAIL neg_value got %h exp FFFF6800", val0_c); else n_pass++;
  endtask

  task automatic test_tare();
    int p, mh, vvn;
    @(negedge clk); tare0 = 1'b1;
    @(negedge clk); tare0 = 1'b0;
    vvn = vv0_n;
    run_conv(1'b0, 24'd1000, 2'b00, 2'b00, p, mh);
    n_chk++; if (vv0_n - vvn !== 1) $display("FAIL tare_valid_cnt got %0d exp 1", vv0_n - vvn); else n_pass++;
    n_chk++; if (val0_c !== 32'd0) $display("FAIL tare_value got %0d exp 0", val0_c); else n_pass++;
    run_conv(1'b0, 24'd1100, 2'b00, 2'b00, p, mh);
    n_chk++; if (val0_c !== 32'd15200) $display("FAIL post_tare_value got %0d exp 15200", val0_c); else n_pass++;
    run_conv(1'b0, 24'd900, 2'b00, 2'b00, p, mh);
    n_chk++; if (val0_c !== 32'hFFFFC4A0) $display("FAIL below_tare_value got %h exp FFFFC4A0", val0_c); else n_pass++;
  endtask

  task automatic test_average();
    int p, mh, vvn;
    vvn = vv2_n;
    run_conv(1'b1, 24'd100, 2'b00, 2'b00, p, mh);
    run_conv(1'b1, 24'd200, 2'b00, 2'b00, p, mh);
    run_conv(1'b1, 24'd300, 2'b00, 2'b00, p, mh);
    n_chk++; if (vv2_n - vvn !== 0) $display("FAIL avg_early_valid got %0d exp 0", vv2_n - vvn); else n_pass++;
    run_conv(1'b1, 24'd400, 2'b00, 2'b00, p, mh);
    n_chk++; if (vv2_n - vvn !== 1) $display("FAIL avg_valid_cnt got %0d exp 1", vv2_n - vvn); else n_pass++;
    n_chk++; if (val2_c !== 32'd38000) $display("FAIL avg_value got %0d exp 38000", val2_c); else n_pass++;
  endtask

  task automatic test_timeout_and_abort();
    @(negedge clk); rst = 1'b1; dout0 = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    repeat (100) @(negedge clk);
    n_chk++; if (to0 !== 1'b0) $display("FAIL timeout_early got %b exp 0", to0); else n_pass++;
    repeat (150) @(negedge clk);
    n_chk++; if (to0 !== 1'b1) $display("FAIL timeout_set got %b exp 1", to0); else n_pass++;
    n_chk++; if (pd0 !== 1'b0) $display("FAIL timeout_pd_sck got %b exp 0", pd0); else n_pass++;
    dout0 = 1'b0;
    @(negedge clk);
    n_chk++; if (to0 !== 1'b0) $display("FAIL timeout_clear got %b exp 0", to0); else n_pass++;
    n_chk++; if ({pd0, busy0} !== 2'b11) $display("FAIL shift_start got %b exp 11", {pd0, busy0}); else n_pass++;
    repeat (9) @(negedge clk);
    n_chk++; if (pd0 !== 1'b1) $display("FAIL mid_pulse_pd_sck got %b exp 1", pd0); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if ({pd0, busy0, to0, rv0, vv0} !== 5'b00000)
      $display("FAIL abort_flags got %b exp 00000", {pd0, busy0, to0, rv0, vv0}); else n_pass++;
    n_chk++; if ({raw0, val0} !== 56'd0) $display("FAIL abort_data got %h exp 0", {raw0, val0}); else n_pass++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if ({pd0, busy0} !== 2'b01) $display("FAIL arm_after_abort got %b exp 01", {pd0, busy0}); else n_pass++;
    dout0 = 1'b1;
  endtask

  initial begin
    test_reset();
    test_mode00();
    test_modes();
    test_mode_change();
    test_negative();
    test_tare();
    test_average();
    test_timeout_and_abort();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
